cbf_decimator: RTL and testbench
================================

Name: cbf_decimator

Overview:
- Output stage placed directly downstream of the batch filter top. It consumes one floatType estimate per clk from the filter's `out`.
- Each sample is converted to saturated signed fixed-point. Every DEC consecutive valid samples are summed (boxcar decimation), and each sum is pushed into a small FIFO.
- The FIFO drains over a valid/ready handshake, so the sample-rate float stream becomes a low-rate fixed-point stream for the host/DAC-side logic.

Parameters:
- DEC, 4, decimation factor (>=1); samples summed per output word.
- OUT_W, 16, width of the converted per-sample fixed-point value (two's complement).
- FRAC, 14, fractional bits of the converted value (LSB = 2^-FRAC).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).
- ACC_W, OUT_W+$clog2(DEC), accumulator/output width (derived, not overridden).

Ports:
- clk  input  1  system clock, same clk as the filter.
- rst  input  1  asynchronous active-low reset; internal state clears while low.
- in  input  $bits(floatType)  filter estimate, floatType from Util.sv (sign, biased exponent, mantissa with hidden 1).
- in_valid  input  1  qualifies `in` for this clk; held low by the system during filter warm-up.
- clr  input  1  synchronous clear of the accumulator, phase counter, FIFO and overflow flag.
- out_data  output  ACC_W  decimated sum at the FIFO head, signed.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid&&out_ready at a clk edge.
- overflow  output  1  sticky; set when a result is dropped because the FIFO is full.

Behaviour:
- Reset (rst=0, async): acc=0, phase=0, stage-1 regs=0/invalid, FIFO empty, out_valid=0, out_data=0, overflow=0.
- clr=1 has the same effect as reset, but on the clk edge. clr overrides any simultaneous push or pop.
- Stage 1, conversion (registered, 1 clk): value = (-1)^s * 1.m * 2^(e-bias), scaled by 2^FRAC and truncated toward zero.
  - Saturation limits are [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - exp==0 (zero or denormal) gives 0.
  - exp all-ones gives the saturated limit by sign.
  - Negative values: magnitude is converted first, then negated, so truncation is symmetric.
  - Stage-1 valid follows in_valid delayed by 1.
- Stage 2, accumulate (registered): on stage-1 valid, result = acc + sext(conv).
  - If phase==DEC-1: push result to the FIFO, acc<=0, phase<=0.
  - Otherwise: acc<=result, phase<=phase+1.
  - With no stage-1 valid, acc and phase hold (gaps in in_valid are tolerated).
  - ACC_W guarantees no wrap: worst case is DEC*(-2^(OUT_W-1)).
- Latency: the DEC-th valid `in` at edge k appears at out_data with out_valid=1 after edge k+2, provided the FIFO was empty.
- FIFO: out_data always shows the head entry; it is 0 when empty.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same clk is legal at any occupancy, including full: the count is unchanged and ordering is preserved.
  - Push with FIFO full and no pop: the new result is dropped, existing entries are untouched, and overflow<=1 until rst or clr.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit or an occupancy counter.
- out_valid and out_data are registered or FIFO-RAM outputs only, with no combinational path from in/in_valid. out_ready may feed pop logic combinationally but never feeds out_valid in the same cycle.
- DEC=1: every valid sample is pushed directly, with phase held at 0.

Test Plan:
- DEC=4, FRAC=14, OUT_W=16; in=+0.5 with in_valid=1 for 8 clks and out_ready=1 -> two outputs of 32768 (ACC_W=18). The first has out_valid 2 clks after the 4th input.
- in=+3.0 x4 -> 4*32767=131068. in=-2.0 x4 -> -131072. in=+inf x1 plus 0.0 x3 -> 32767.
- in=-0.75 then +0.75, each with the LSB truncation case 0.000030517 (=2^-15) -> converts to 0; the sum of -12288, 12288, 0, 0 gives 0.
- in_valid toggled 1,0,0,1,1,0,1 carrying 0.25 -> exactly one output of 16384, produced after the 4th valid sample.
- out_ready=0, 5 complete batches -> out_valid=1 with 4 entries stored in order, 5th dropped, overflow=1. Then out_ready=1 -> 4 words drain in order, and overflow stays 1 until clr.
- rst pulsed low mid-batch (phase=2) with 2 entries queued -> out_valid=0 and overflow=0 immediately. After release, the next batch needs 4 fresh valid samples.

Source files
------------

// File: rtl/cbf_decimator.sv
// Float-to-fixed conversion, DEC-sample boxcar decimation and a small output FIFO.
// Latency: DEC-th valid sample to out_valid is 2 clk; FIFO drains on out_valid&&out_ready, drops and flags overflow when full.

package cbf_util_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } floatType;
  localparam int FLT_BIAS = 127;
endpackage

module cbf_decimator
  import cbf_util_pkg::*;
#(
  parameter  int DEC        = 4,
  parameter  int OUT_W      = 16,
  parameter  int FRAC       = 14,
  parameter  int FIFO_DEPTH = 4,
  localparam int ACC_W      = OUT_W + $clog2(DEC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  floatType                in,
  input  logic                    in_valid,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  localparam int PH_W = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PH_W-1:0]        PH_LAST  = PH_W'(DEC - 1);
  localparam logic [AW:0]            FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic signed [OUT_W-1:0] CONV_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] CONV_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------- stage 1: float -> saturated fixed point ----------------
  int                        sh;
  logic [7:0]                sh_amt;
  logic [OUT_W+23:0]         sig_ext;
  logic [OUT_W+23:0]         shifted;
  logic [OUT_W-1:0]          mag;
  logic signed [OUT_W-1:0]   conv_nx;
  logic signed [OUT_W-1:0]   conv_q;
  logic                      s1_vld;

  always_comb begin
    sh      = int'(in.exp) - FLT_BIAS + FRAC;
    sh_amt  = sh[7:0];
    sig_ext = {{OUT_W{1'b0}}, 1'b1, in.mant};
    shifted = sig_ext << sh_amt;
    mag     = shifted[23 +: OUT_W];
    conv_nx = '0;
    if (in.exp == 8'd0) begin
      conv_nx = '0;
    end else if (in.exp == 8'hFF || sh >= OUT_W - 1) begin
      // Magnitude >= 2^(OUT_W-1): the negative limit is exact, the positive one clips.
      conv_nx = in.sign ? CONV_MIN : CONV_MAX;
    end else if (sh < 0) begin
      conv_nx = '0;
    end else begin
      conv_nx = in.sign ? -$signed(mag) : $signed(mag);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_q <= '0;
      s1_vld <= 1'b0;
    end else if (clr) begin
      conv_q <= '0;
      s1_vld <= 1'b0;
    end else begin
      conv_q <= conv_nx;
      s1_vld <= in_valid;
    end
  end

  // ---------------- stage 2: boxcar accumulate ----------------
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] conv_ext;
  logic signed [ACC_W-1:0] sum;
  logic [PH_W-1:0]         phase;
  logic                    push_vld;
  logic signed [ACC_W-1:0] push_dat;

  always_comb begin
    conv_ext = ACC_W'(conv_q);
    sum      = acc + conv_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      phase    <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else if (clr) begin
      acc      <= '0;
      phase    <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= 1'b0;
      if (s1_vld) begin
        if (phase == PH_LAST) begin
          push_vld <= 1'b1;
          push_dat <= sum;
          acc      <= '0;
          phase    <= '0;
        end else begin
          acc   <= sum;
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic signed [ACC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             cnt;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    wr_en;
  logic                    drop;

  always_comb begin
    full  = (cnt == FULL_CNT);
    empty = (cnt == '0);
    pop   = !empty && out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    wr_en = push_vld && (!full || pop);
    drop  = push_vld && full && !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    out_valid = !empty;
    out_data  = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_cbf_decimator.sv
// Directed bench for cbf_decimator (DEC=4, OUT_W=16, FRAC=14, FIFO_DEPTH=4).
module tb_cbf_decimator;

  localparam int ACC_W = 18;

  localparam logic [31:0] F_P0_25 = 32'h3E800000;
  localparam logic [31:0] F_P0_5  = 32'h3F000000;
  localparam logic [31:0] F_P0_75 = 32'h3F400000;
  localparam logic [31:0] F_N0_75 = 32'hBF400000;
  localparam logic [31:0] F_P1_0  = 32'h3F800000;
  localparam logic [31:0] F_P1_5  = 32'h3FC00000;
  localparam logic [31:0] F_P3_0  = 32'h40400000;
  localparam logic [31:0] F_N2_0  = 32'hC0000000;
  localparam logic [31:0] F_PINF  = 32'h7F800000;
  localparam logic [31:0] F_ZERO  = 32'h00000000;
  localparam logic [31:0] F_P2M15 = 32'h38000000;
  localparam logic [31:0] F_N2M15 = 32'hB8000000;

  logic                    clk = 1'b0;
  logic                    rst;
  cbf_util_pkg::floatType  din;
  logic                    in_valid;
  logic                    clr;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overflow;

  int n_chk  = 0;
  int n_fail = 0;
  longint got_q[$];

  cbf_decimator #(.DEC(4), .OUT_W(16), .FRAC(14), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (in_valid),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so the handshake seen here holds at the next posedge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) got_q.push_back(longint'(out_data));
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input logic vld);
    din      = v;
    in_valid = vld;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic batch(input logic [31:0] v);
    for (int i = 0; i < 4; i++) send(v, 1'b1);
  endtask

  task automatic expect_q(input string tag, input longint exp[$]);
    check_val({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got_q.size()) check_val($sformatf("%s_w%0d", tag, i), got_q[i], exp[i]);
    end
    got_q.delete();
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = F_ZERO;
    #12;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_overflow", overflow, 0);
    @(negedge clk); rst = 1'b1;
    tick();

    // Two batches of 0.5 with latency check on the first.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(F_P0_5, 1'b1);
    din = F_P0_5; in_valid = 1'b1; tick();          // 4th valid sample at edge k
    check_val("lat_k0_valid", out_valid, 0);
    tick();                                          // edge k+1
    check_val("lat_k1_valid", out_valid, 0);
    tick();                                          // edge k+2
    check_val("lat_k2_valid", out_valid, 1);
    check_val("lat_k2_data", out_data, 32768);
    send(F_P0_5, 1'b1);
    send(F_P0_5, 1'b1);
    idle(4);
    expect_q("half", '{32768, 32768});

    // Saturation, exact negative limit, infinity.
    batch(F_P3_0);
    batch(F_N2_0);
    send(F_PINF, 1'b1);
    for (int i = 0; i < 3; i++) send(F_ZERO, 1'b1);
    idle(4);
    expect_q("sat", '{131068, -131072, 32767});

    // Symmetric truncation: +-0.75 and +-2^-15.
    send(F_N0_75, 1'b1);
    send(F_P0_75, 1'b1);
    send(F_P2M15, 1'b1);
    send(F_N2M15, 1'b1);
    idle(4);
    expect_q("trunc", '{0});

    // Gaps in in_valid: 1,0,0,1,1,0,1.
    send(F_P0_25, 1'b1);
    send(F_P0_25, 1'b0);
    send(F_P0_25, 1'b0);
    send(F_P0_25, 1'b1);
    send(F_P0_25, 1'b1);
    idle(3);
    check_val("gap_none_yet", got_q.size(), 0);
    send(F_P0_25, 1'b0);
    send(F_P0_25, 1'b1);
    idle(4);
    expect_q("gap", '{16384});

    // Backpressure: five batches, fifth dropped.
    out_ready = 1'b0;
    batch(F_P0_25);
    batch(F_P0_5);
    batch(F_P0_75);
    batch(F_P1_0);
    batch(F_P1_5);
    idle(3);
    check_val("bp_out_valid", out_valid, 1);
    check_val("bp_head", out_data, 16384);
    check_val("bp_overflow", overflow, 1);
    out_ready = 1'b1;
    idle(6);
    expect_q("drain", '{16384, 32768, 49152, 65536});
    check_val("drain_empty", out_valid, 0);
    check_val("drain_ovf_sticky", overflow, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check_val("clr_overflow", overflow, 0);

    // Async reset mid-batch with two entries queued.
    out_ready = 1'b0;
    batch(F_P0_5);
    batch(F_P0_5);
    send(F_P0_5, 1'b1);
    send(F_P0_5, 1'b1);
    idle(3);
    check_val("prerst_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check_val("rst_mid_valid", out_valid, 0);
    check_val("rst_mid_data", out_data, 0);
    check_val("rst_mid_ovf", overflow, 0);
    @(negedge clk); rst = 1'b1;
    tick();
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(F_P0_5, 1'b1);
    idle(4);
    check_val("rst_phase_cleared", got_q.size(), 0);
    send(F_P0_5, 1'b1);
    idle(4);
    expect_q("post_rst", '{32768});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
